// File: rtl/apb_rf_pkg.sv
// Shared types and helpers for the APB register bank: FSM states, index sizing, byte merge.
package apb_rf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Upper bounds for the width-generic byte merge; callers slice the result.
  localparam int unsigned MAX_DATA_W   = 1024;
  localparam int unsigned MAX_STRB_W   = MAX_DATA_W / 8;
  localparam int unsigned NUM_REGS_DEF = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IDX_WIDTH = idx_width(NUM_REGS_DEF);

  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_v,
    input logic [MAX_DATA_W-1:0] new_v,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] res;
    for (int b = 0; b < MAX_STRB_W; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_rf_wait_ctrl.sv
// Access sequencer: IDLE -> (WAIT x WAIT_STATES) -> RESP -> IDLE.
// commit marks the edge entering RESP; ready is the registered one-cycle completion pulse.
module apb_rf_wait_ctrl
  import apb_rf_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic capture,
  output logic commit,
  output logic ready
);

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e     state_q;
  logic [3:0] cnt_q;

  assign capture = (state_q == ST_IDLE) && req;
  assign commit  = ((state_q == ST_IDLE) && req && (WAIT_STATES == 0)) ||
                   ((state_q == ST_WAIT) && (cnt_q == 4'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ready   <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (WAIT_STATES == 0) begin
              state_q <= ST_RESP;
              ready   <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_RESP;
            ready   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/apb_reg_bank.sv
// Register bank behind the APB slave: strobe-merged writable words, hardware-sourced read-only words,
// programmable response latency and error reporting for illegal or read-only accesses.
module apb_reg_bank
  import apb_rf_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH  = 32,
  parameter int unsigned          DATA_WIDTH  = 32,
  parameter int unsigned          STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned          NUM_REGS    = NUM_REGS_DEF,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
  parameter int unsigned          WAIT_STATES = 0
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [ADDR_WIDTH-1:0]          RegADDR,
  input  logic [DATA_WIDTH-1:0]          RegWDATA,
  input  logic                           RegWRITE,
  input  logic                           RegENABLE,
  input  logic [STRB_WIDTH-1:0]          RegSTRB,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] RegHWIN,
  output logic [DATA_WIDTH-1:0]          RegRDATA,
  output logic                           RegSLVERR,
  output logic                           RegREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] RegOUT
);

  localparam int unsigned IDX_W  = idx_width(NUM_REGS);
  localparam int unsigned WIDX_W = ADDR_WIDTH - 2;

  logic capture, commit;

  apb_rf_wait_ctrl #(.WAIT_STATES(WAIT_STATES)) u_wait_ctrl (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .req     (RegENABLE),
    .capture (capture),
    .commit  (commit),
    .ready   (RegREADY)
  );

  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [STRB_WIDTH-1:0] strb_q,  strb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  slverr_q, slverr_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // With zero wait states the commit edge is the capture edge, so live inputs are used then.
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_write;
  logic [STRB_WIDTH-1:0] acc_strb;
  logic [WIDX_W-1:0]     word_idx;
  logic [IDX_W-1:0]      sel;
  logic                  legal, ro;
  logic [DATA_WIDTH-1:0] rd_val, merged;
  logic [MAX_DATA_W-1:0] merged_full;
  logic                  unused_merge_hi;

  assign acc_addr  = capture ? RegADDR  : addr_q;
  assign acc_wdata = capture ? RegWDATA : wdata_q;
  assign acc_write = capture ? RegWRITE : write_q;
  assign acc_strb  = capture ? RegSTRB  : strb_q;

  assign word_idx = acc_addr[ADDR_WIDTH-1:2];
  assign sel      = word_idx[IDX_W-1:0];
  assign legal    = (acc_addr[1:0] == 2'b00) && (word_idx < WIDX_W'(NUM_REGS));
  assign ro       = RO_MASK[sel];
  assign rd_val   = ro ? RegHWIN[32'(sel) * DATA_WIDTH +: DATA_WIDTH] : regs_q[sel];

  assign merged_full     = byte_merge(MAX_DATA_W'(regs_q[sel]), MAX_DATA_W'(acc_wdata),
                                      MAX_STRB_W'(acc_strb));
  assign merged          = merged_full[DATA_WIDTH-1:0];
  assign unused_merge_hi = ^merged_full[MAX_DATA_W-1:DATA_WIDTH];

  always_comb begin
    addr_d   = capture ? RegADDR  : addr_q;
    wdata_d  = capture ? RegWDATA : wdata_q;
    write_d  = capture ? RegWRITE : write_q;
    strb_d   = capture ? RegSTRB  : strb_q;
    regs_d   = regs_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
    if (commit) begin
      slverr_d = !legal || (acc_write && ro);
      if (acc_write) begin
        if (legal && !ro) regs_d[sel] = merged;
      end else begin
        rdata_d = legal ? rd_val : '0;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      strb_q   <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      strb_q   <= strb_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      regs_q   <= regs_d;
    end
  end

  assign RegRDATA  = rdata_q;
  assign RegSLVERR = slverr_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign RegOUT[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Two bank instances (zero and three wait states) driven by directed and random accesses
// and compared against an array model of the register file.
module tb_apb_reg_bank;

  localparam int NR = 16;
  localparam int DW = 32;
  localparam logic [NR-1:0] ROM = 16'h0204;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       addr, wdata;
  logic              write;
  logic [3:0]        strb;
  logic [NR*DW-1:0]  hwin;
  logic              en0, en3;
  logic [31:0]       rdata0, rdata3;
  logic              slverr0, slverr3, ready0, ready3;
  logic [NR*DW-1:0]  out0, out3;

  always #5 clk = ~clk;

  apb_reg_bank #(.NUM_REGS(NR), .RO_MASK(ROM), .WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESETn(rst_n), .RegADDR(addr), .RegWDATA(wdata), .RegWRITE(write),
    .RegENABLE(en0), .RegSTRB(strb), .RegHWIN(hwin), .RegRDATA(rdata0),
    .RegSLVERR(slverr0), .RegREADY(ready0), .RegOUT(out0));

  apb_reg_bank #(.NUM_REGS(NR), .RO_MASK(ROM), .WAIT_STATES(3)) dut3 (
    .PCLK(clk), .PRESETn(rst_n), .RegADDR(addr), .RegWDATA(wdata), .RegWRITE(write),
    .RegENABLE(en3), .RegSTRB(strb), .RegHWIN(hwin), .RegRDATA(rdata3),
    .RegSLVERR(slverr3), .RegREADY(ready3), .RegOUT(out3));

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mem [2][NR];
  logic [31:0] last_rd [2];
  logic        last_err [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < NR; i++) mem[w][i] = '0;
      last_rd[w]  = '0;
      last_err[w] = 1'b0;
    end
  endtask

  task automatic sample(input int w, output logic [31:0] rd, output logic er,
                        output logic rdy, output logic [NR*DW-1:0] o);
    if (w == 0) begin rd = rdata0; er = slverr0; rdy = ready0; o = out0; end
    else        begin rd = rdata3; er = slverr3; rdy = ready3; o = out3; end
  endtask

  task automatic check_outs(input int w, input logic [NR*DW-1:0] o);
    for (int i = 0; i < NR; i++)
      check_val($sformatf("regout%0d[%0d]", w, i), o[i*DW +: DW], ROM[i] ? 32'h0 : mem[w][i]);
  endtask

  task automatic run_acc(input int w, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd_o, output logic er_o);
    int           idx = int'(a >> 2);
    int           cyc = 0;
    bit           done = 0;
    bit           legal, ro;
    logic [31:0]  m;
    logic [31:0]  rd;
    logic         er, rdy;
    logic [NR*DW-1:0] o;
    legal = (a[1:0] == 2'b00) && (idx < NR);
    ro    = 0;
    if (legal) ro = ROM[idx];
    // Expected outcome from the access rules, applied to the model before the access runs.
    if (wr) begin
      last_err[w] = !legal || ro;
      if (legal && !ro) begin
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        mem[w][idx] = (mem[w][idx] & ~m) | (d & m);
      end
    end else begin
      last_err[w] = !legal;
      if (!legal)  last_rd[w] = '0;
      else if (ro) last_rd[w] = hwin[idx*DW +: DW];
      else         last_rd[w] = mem[w][idx];
    end
    @(negedge clk);
    addr = a; wdata = d; write = wr; strb = s;
    if (w == 0) en0 = 1'b1; else en3 = 1'b1;
    while (!done) begin
      @(negedge clk);
      cyc++;
      sample(w, rd, er, rdy, o);
      if (rdy) done = 1;
      else if (cyc > 40) begin
        check_val("ready_timeout", 32'(cyc), 32'(w == 0 ? 1 : 4));
        done = 1;
      end else begin
        addr = $urandom; wdata = $urandom; write = 1'($urandom); strb = 4'($urandom);
      end
    end
    en0 = 1'b0; en3 = 1'b0;
    check_val($sformatf("latency%0d", w), 32'(cyc), 32'(w == 0 ? 1 : 4));
    check_val($sformatf("rdata%0d", w), rd, last_rd[w]);
    check_val($sformatf("slverr%0d", w), 32'(er), 32'(last_err[w]));
    rd_o = rd; er_o = er;
    @(negedge clk);
    sample(w, rd, er, rdy, o);
    check_val($sformatf("ready_pulse%0d", w), 32'(rdy), 32'h0);
    check_outs(w, o);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    bit          seen;
    rst_n = 1'b0; en0 = 1'b0; en3 = 1'b0;
    addr = '0; wdata = '0; write = 1'b0; strb = '0; hwin = '0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_ready0", 32'(ready0), 32'h0);
    check_val("rst_rdata0", rdata0, 32'h0);
    check_val("rst_slverr3", 32'(slverr3), 32'h0);
    check_outs(0, out0);

    run_acc(0, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er);
    check_val("rst_read_idx3", rd, 32'h0);

    for (int w = 0; w < 2; w++) begin
      run_acc(w, 1'b1, 32'h0C, 32'hAABBCCDD, 4'b1111, rd, er);
      run_acc(w, 1'b1, 32'h0C, 32'h11223344, 4'b0101, rd, er);
      run_acc(w, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er);
      check_val("partial_strobe", rd, 32'hAA22CC44);
      run_acc(w, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'b0000, rd, er);
      check_val("zero_strobe_err", 32'(er), 32'h0);
    end

    hwin[2*DW +: DW] = 32'hCAFE0001;
    run_acc(0, 1'b1, 32'h08, 32'h12345678, 4'hF, rd, er);
    check_val("ro_write_err", 32'(er), 32'h1);
    run_acc(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er);
    check_val("ro_read_val", rd, 32'hCAFE0001);
    check_val("ro_read_err", 32'(er), 32'h0);

    run_acc(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er);
    check_val("oob_read_val", rd, 32'h0);
    check_val("oob_read_err", 32'(er), 32'h1);
    run_acc(0, 1'b1, 32'h06, 32'hDEADBEEF, 4'hF, rd, er);
    check_val("misalign_wr_err", 32'(er), 32'h1);

    for (int i = 0; i < 120; i++) begin
      int          w   = $urandom_range(0, 1);
      logic [31:0] a   = 32'($urandom_range(0, 19)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      for (int r = 0; r < NR; r++) hwin[r*DW +: DW] = $urandom;
      run_acc(w, 1'($urandom), a, $urandom, 4'($urandom), rd, er);
    end

    // Reset while the three-wait-state instance is mid-access.
    run_acc(1, 1'b1, 32'h14, 32'h5A5A5A5A, 4'hF, rd, er);
    @(negedge clk);
    addr = 32'h14; wdata = 32'h0F0F0F0F; write = 1'b1; strb = 4'hF; en3 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    seen = ready3;
    rst_n = 1'b0; en3 = 1'b0;
    model_clear();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen = seen | ready3;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen = seen | ready3;
    end
    check_val("rst_mid_no_ready", 32'(seen), 32'h0);
    run_acc(1, 1'b0, 32'h14, 32'h0, 4'h0, rd, er);
    check_val("rst_mid_reg_zero", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
